// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg
//   Shared definitions for the RAM copy/fill engine: FSM state encoding,
//   job mode encodings and a helper that gives the number of byte-offset
//   bits inside one RAM word.
package ram_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // log2(DATA_WIDTH/8): number of low address bits that select a byte
    // inside a word. A word-aligned address has all of these bits zero.
    function automatic int unsigned word_off_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ram_dma_copier.sv
// ram_dma_copier
//   Word-granular copy/fill engine acting as initiator on a single-port RAM.
//   One job at a time: started by a start_i pulse in IDLE, finished by a
//   one-cycle done_o pulse.
//
// Ports
//   clk, rstn_i            clock, asynchronous active-low reset
//   start_i                job request (sampled only in IDLE)
//   mode_i                 0 = copy, 1 = fill (latched at start)
//   src_addr_i/dst_addr_i  byte addresses (latched at start)
//   len_i                  number of words (latched at start)
//   fill_data_i            fill pattern (latched at start)
//   abort_i                stop the running job
//   busy_o                 job in progress (RD or WR)
//   done_o                 one-cycle end-of-job pulse
//   err_o                  last job rejected; held until next accepted start
//   ram_en_o/we_o/addr_o/wdata_o/be_o   RAM request
//   ram_rdata_i            RAM read data, valid the cycle after a read
//
// Handshake: there is no backpressure. A RAM access is issued in every
// cycle where ram_en_o is high; read data is consumed exactly one cycle
// later, in the WR state that always follows an RD state.
module ram_dma_copier
    import ram_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic                    mode_i,
    input  logic [ADDR_WIDTH-1:0]   src_addr_i,
    input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    input  logic [DATA_WIDTH-1:0]   fill_data_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int          BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS = word_off_bits(DATA_WIDTH);

    // Mask of the byte-offset bits; zero when a word is a single byte.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFF_BITS) - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BE_WIDTH);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RD   = ST_RD;
    localparam logic [1:0] WR   = ST_WR;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]            state_q, state_d;
    logic                  mode_q,  mode_d;
    logic [ADDR_WIDTH-1:0] src_q,   src_d;
    logic [ADDR_WIDTH-1:0] dst_q,   dst_d;
    logic [LEN_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] fill_q,  fill_d;
    logic                  err_q,   err_d;

    logic misaligned;

    // The source address only matters for copies.
    assign misaligned = ((dst_addr_i & ALIGN_MASK) != '0) ||
                        ((mode_i == MODE_COPY) && ((src_addr_i & ALIGN_MASK) != '0));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d = mode_i;
                    src_d  = src_addr_i;
                    dst_d  = dst_addr_i;
                    cnt_d  = len_i;
                    fill_d = fill_data_i;
                    err_d  = 1'b0;
                    if (len_i == '0) begin
                        state_d = DONE;
                    end else if (misaligned) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (mode_i == MODE_COPY) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end

            RD: begin
                // An abort here drops the read that was just issued.
                state_d = abort_i ? DONE : WR;
            end

            WR: begin
                // The write of this cycle is already on the bus, so an abort
                // still lets it complete; only later accesses are cancelled.
                dst_d = dst_q + STEP;
                if (mode_q == MODE_COPY) begin
                    src_d = src_q + STEP;
                end
                cnt_d = cnt_q - LEN_WIDTH'(1);
                if ((cnt_q == LEN_WIDTH'(1)) || abort_i) begin
                    state_d = DONE;
                end else if (mode_q == MODE_COPY) begin
                    state_d = RD;
                end else begin
                    state_d = WR;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

    assign busy_o = (state_q == RD) || (state_q == WR);
    assign done_o = (state_q == DONE);
    assign err_o  = err_q;

    assign ram_en_o   = busy_o;
    assign ram_we_o   = (state_q == WR);
    assign ram_be_o   = (state_q == WR) ? {BE_WIDTH{1'b1}} : '0;
    assign ram_addr_o = (state_q == RD) ? src_q :
                        (state_q == WR) ? dst_q : '0;

    // Copy writes forward the word read in the previous cycle straight from
    // the RAM; this is the only input-to-output combinational path.
    assign ram_wdata_o = (state_q != WR)       ? '0 :
                         (mode_q == MODE_COPY) ? ram_rdata_i : fill_q;

endmodule

// File: tb/tb_ram_dma_copier.sv
// tb_ram_dma_copier
//   Directed bench for ram_dma_copier with a 64-word RAM model. Cycle 0 is
//   the cycle in which start_i is presented in IDLE; outputs are sampled at
//   the falling edge of each following cycle.
module tb_ram_dma_copier;
    import ram_dma_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [AW-1:0] src_addr_i = '0;
    logic [AW-1:0] dst_addr_i = '0;
    logic [LW-1:0] len_i = '0;
    logic [DW-1:0] fill_data_i = '0;
    logic          abort_i = 1'b0;
    logic          busy_o, done_o, err_o, ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [3:0]    ram_be_o;
    logic [DW-1:0] ram_rdata_i;

    int n_cmp = 0;
    int n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ram_dma_copier #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rstn_i(rstn_i), .start_i(start_i), .mode_i(mode_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .fill_data_i(fill_data_i), .abort_i(abort_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o),
        .ram_rdata_i(ram_rdata_i)
    );

    // ---------------- RAM model ----------------
    logic [DW-1:0] mem [64];
    logic          mem_clr = 1'b0;
    logic          pre_we = 1'b0;
    logic [5:0]    pre_idx = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end else begin
                ram_rdata_i <= mem[ram_addr_o[7:2]];
            end
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
        logic          busy;
    } acc_t;

    acc_t acc_q[$];
    int   done_cyc;
    logic err_done;
    logic busy_done;

    task automatic mem_write(input logic [5:0] idx, input logic [DW-1:0] data);
        @(negedge clk);
        pre_idx = idx; pre_data = data; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Start a job in cycle 0 and log every RAM access until done_o.
    // abort_cyc / busy_start_cyc (0 = never) raise abort_i / a spurious
    // start_i during that cycle.
    task automatic run_job(input logic mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [LW-1:0] len, input logic [DW-1:0] fill,
                           input int abort_cyc, input int busy_start_cyc);
        acc_t a;
        acc_q.delete();
        done_cyc = -1;
        err_done = 1'bx;
        busy_done = 1'bx;
        @(negedge clk);
        mode_i = mode; src_addr_i = src; dst_addr_i = dst; len_i = len;
        fill_data_i = fill; start_i = 1'b1;
        for (int k = 1; k <= 64 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (ram_en_o) begin
                a.cyc = k; a.we = ram_we_o; a.addr = ram_addr_o;
                a.wdata = ram_wdata_o; a.be = ram_be_o; a.busy = busy_o;
                acc_q.push_back(a);
            end
            if (done_o) begin
                done_cyc = k; err_done = err_o; busy_done = busy_o;
            end
            start_i = (k == busy_start_cyc);
            if (k == busy_start_cyc) begin
                mode_i = MODE_FILL; dst_addr_i = 8'h80; len_i = 8'd1; fill_data_i = 32'hBAD0_BAD0;
            end
            abort_i = (k == abort_cyc);
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        if (done_cyc < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL job_timeout: no done_o within 64 cycles");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn_i = 1'b0;
        mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        n_cmp++;
        if ({busy_o, done_o, err_o, ram_en_o, ram_we_o} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                               {busy_o, done_o, err_o, ram_en_o, ram_we_o});
        end
        n_cmp++;
        if ({ram_addr_o, ram_wdata_o, ram_be_o} !== 44'h0) begin
            n_fail++; $display("FAIL reset_bus: got %h expected 0",
                               {ram_addr_o, ram_wdata_o, ram_be_o});
        end
        rstn_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [AW-1:0] ea;
        run_job(MODE_FILL, 8'h00, 8'h10, 8'd4, 32'hA5A5_0001, 0, 0);
        n_cmp++;
        if (done_cyc !== 5 || err_done !== 1'b0 || busy_done !== 1'b0) begin
            n_fail++; $display("FAIL fill_done: got cyc=%0d err=%b busy=%b expected cyc=5 err=0 busy=0",
                               done_cyc, err_done, busy_done);
        end
        n_cmp++;
        if (acc_q.size() !== 4) begin
            n_fail++; $display("FAIL fill_count: got %0d expected 4", acc_q.size());
        end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            ea = 8'h10 + 8'(4 * i);
            n_cmp++;
            if ({8'(acc_q[i].cyc), acc_q[i].we, acc_q[i].addr, acc_q[i].wdata, acc_q[i].be, acc_q[i].busy}
                !== {8'(i + 1), 1'b1, ea, 32'hA5A5_0001, 4'hF, 1'b1}) begin
                n_fail++; $display("FAIL fill_acc%0d: got cyc=%0d we=%b a=%h d=%h be=%h expected cyc=%0d we=1 a=%h d=a5a50001 be=f",
                                   i, acc_q[i].cyc, acc_q[i].we, acc_q[i].addr, acc_q[i].wdata, acc_q[i].be, i + 1, ea);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[4 + i] !== 32'hA5A5_0001) begin
                n_fail++; $display("FAIL fill_mem%0d: got %h expected a5a50001", i, mem[4 + i]);
            end
        end
    endtask

    task automatic test_copy();
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        for (int i = 0; i < 4; i++) mem_write(6'(i), 32'(i + 1));
        run_job(MODE_COPY, 8'h00, 8'h40, 8'd4, 32'h0, 0, 0);
        n_cmp++;
        if (done_cyc !== 9 || err_done !== 1'b0) begin
            n_fail++; $display("FAIL copy_done: got cyc=%0d err=%b expected cyc=9 err=0", done_cyc, err_done);
        end
        n_cmp++;
        if (acc_q.size() !== 8) begin
            n_fail++; $display("FAIL copy_count: got %0d expected 8", acc_q.size());
        end
        for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
            ewe = i[0];
            ea  = ewe ? 8'h40 + 8'(4 * (i / 2)) : 8'(4 * (i / 2));
            ed  = ewe ? 32'(i / 2 + 1) : 32'h0;
            n_cmp++;
            if ({8'(acc_q[i].cyc), acc_q[i].we, acc_q[i].addr, acc_q[i].wdata, acc_q[i].be}
                !== {8'(i + 1), ewe, ea, ed, {4{ewe}}}) begin
                n_fail++; $display("FAIL copy_acc%0d: got cyc=%0d we=%b a=%h d=%h be=%h expected cyc=%0d we=%b a=%h d=%h",
                                   i, acc_q[i].cyc, acc_q[i].we, acc_q[i].addr, acc_q[i].wdata, acc_q[i].be,
                                   i + 1, ewe, ea, ed);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[16 + i] !== 32'(i + 1)) begin
                n_fail++; $display("FAIL copy_mem%0d: got %h expected %h", i, mem[16 + i], 32'(i + 1));
            end
        end
    endtask

    task automatic test_reject();
        run_job(MODE_COPY, 8'h02, 8'h20, 8'd4, 32'h0, 0, 0);
        n_cmp++;
        if (done_cyc !== 1 || err_done !== 1'b1 || acc_q.size() !== 0) begin
            n_fail++; $display("FAIL reject_misaligned: got cyc=%0d err=%b acc=%0d expected cyc=1 err=1 acc=0",
                               done_cyc, err_done, acc_q.size());
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (err_o !== 1'b1) begin
            n_fail++; $display("FAIL reject_err_held: got %b expected 1", err_o);
        end
        run_job(MODE_COPY, 8'h00, 8'h20, 8'd0, 32'h0, 0, 0);
        n_cmp++;
        if (done_cyc !== 1 || err_done !== 1'b0 || acc_q.size() !== 0) begin
            n_fail++; $display("FAIL reject_len0: got cyc=%0d err=%b acc=%0d expected cyc=1 err=0 acc=0",
                               done_cyc, err_done, acc_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a[0] = 8'hF8; exp_a[1] = 8'hFC; exp_a[2] = 8'h00; exp_a[3] = 8'h04;
        run_job(MODE_FILL, 8'h00, 8'hF8, 8'd4, 32'h5A5A_0F0F, 0, 0);
        n_cmp++;
        if (done_cyc !== 5 || acc_q.size() !== 4) begin
            n_fail++; $display("FAIL wrap_done: got cyc=%0d acc=%0d expected cyc=5 acc=4", done_cyc, acc_q.size());
        end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            n_cmp++;
            if ({acc_q[i].we, acc_q[i].addr} !== {1'b1, exp_a[i]}) begin
                n_fail++; $display("FAIL wrap_addr%0d: got we=%b a=%h expected we=1 a=%h",
                                   i, acc_q[i].we, acc_q[i].addr, exp_a[i]);
            end
        end
        n_cmp++;
        if ({mem[62], mem[63], mem[0], mem[1]} !== {4{32'h5A5A_0F0F}}) begin
            n_fail++; $display("FAIL wrap_mem: got %h %h %h %h expected 5a5a0f0f x4",
                               mem[62], mem[63], mem[0], mem[1]);
        end
    endtask

    task automatic test_abort_busy_start();
        mem_write(6'd0, 32'h0000_0011);
        mem_write(6'd1, 32'h0000_0022);
        mem_write(6'd25, 32'hDEAD_BEEF);
        mem_write(6'd32, 32'hCAFE_F00D);
        // Abort lands in cycle 3, the RD of word 2; a spurious start in cycle 2.
        run_job(MODE_COPY, 8'h00, 8'h60, 8'd8, 32'h0, 3, 2);
        n_cmp++;
        if (done_cyc !== 4 || err_done !== 1'b0 || acc_q.size() !== 3) begin
            n_fail++; $display("FAIL abort_done: got cyc=%0d err=%b acc=%0d expected cyc=4 err=0 acc=3",
                               done_cyc, err_done, acc_q.size());
        end
        if (acc_q.size() == 3) begin
            n_cmp++;
            if ({acc_q[2].cyc[7:0], acc_q[2].we, acc_q[2].addr} !== {8'd3, 1'b0, 8'h04}) begin
                n_fail++; $display("FAIL abort_last_acc: got cyc=%0d we=%b a=%h expected cyc=3 we=0 a=04",
                                   acc_q[2].cyc, acc_q[2].we, acc_q[2].addr);
            end
        end
        n_cmp++;
        if ({mem[24], mem[25], mem[32]} !== {32'h0000_0011, 32'hDEAD_BEEF, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL abort_mem: got %h %h %h expected 00000011 deadbeef cafef00d",
                               mem[24], mem[25], mem[32]);
        end
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk);
        mode_i = MODE_FILL; dst_addr_i = 8'h90; len_i = 8'd8;
        fill_data_i = 32'h0000_0077; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ram_en_o, ram_we_o, ram_addr_o} !== {1'b1, 1'b1, 8'h94}) begin
            n_fail++; $display("FAIL midrst_pre: got en=%b we=%b a=%h expected en=1 we=1 a=94",
                               ram_en_o, ram_we_o, ram_addr_o);
        end
        rstn_i = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, done_o, err_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o} !== 49'h0) begin
            n_fail++; $display("FAIL midrst_outputs: got %h expected 0",
                               {busy_o, done_o, err_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o});
        end
        @(negedge clk);
        rstn_i = 1'b1;
        n_cmp++;
        if ({mem[36], mem[37]} !== {32'h0000_0077, 32'h0}) begin
            n_fail++; $display("FAIL midrst_mem: got %h %h expected 00000077 00000000", mem[36], mem[37]);
        end
        run_job(MODE_FILL, 8'h00, 8'hA0, 8'd1, 32'h1234_5678, 0, 0);
        n_cmp++;
        if (done_cyc !== 2 || acc_q.size() !== 1 || mem[40] !== 32'h1234_5678) begin
            n_fail++; $display("FAIL midrst_after: got cyc=%0d acc=%0d mem=%h expected cyc=2 acc=1 mem=12345678",
                               done_cyc, acc_q.size(), mem[40]);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_reject();
        test_wrap();
        test_abort_busy_start();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_dma_copier.md
# ram_dma_copier

Word-granular copy/fill engine that acts as the initiator on the single-port RAM interface: it drives en/addr/wdata/we/be and consumes rdata, which the RAM returns one cycle after the read is issued. It sits beside the core-side memory mux and clears, initialises or moves RAM regions without core involvement. One job runs at a time. The job is started by a pulse and ends with a done pulse.

## Interface
- ADDR_WIDTH, 8, byte-address width; must match the RAM.
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- LEN_WIDTH, 8, width of the word-count field.
- clk  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  0 = copy, 1 = fill; latched at start.
- src_addr_i  in  ADDR_WIDTH  copy source byte address; latched at start.
- dst_addr_i  in  ADDR_WIDTH  destination byte address; latched at start.
- len_i  in  LEN_WIDTH  number of words; latched at start.
- fill_data_i  in  DATA_WIDTH  fill pattern; latched at start.
- abort_i  in  1  abort the running job.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at the end of a job.
- err_o  out  1  last job was rejected; held until the next accepted start.
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_be_o  out  DATA_WIDTH/8  byte enables; all ones during writes, 0 otherwise.
- ram_rdata_i  in  DATA_WIDTH  RAM read data; valid the cycle after a read.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- Transitions from IDLE:
  - start_i=1 → latch all job inputs and clear err_o.
  - len=0 → DONE; err_o stays 0.
  - Misaligned address (low log2(DATA_WIDTH/8) bits nonzero; src checked only in copy mode) → DONE with err_o=1.
  - Otherwise, copy mode → RD; fill mode → WR.
- Access driving:
  - RD: en=1, we=0, addr=src pointer.
  - WR: en=1, we=1, be=all ones, addr=dst pointer.
  - WR wdata: ram_rdata_i (combinational pass-through) in copy mode; latched fill pattern in fill mode.
- Pointer and counter updates:
  - After each WR: dst += DATA_WIDTH/8; src += DATA_WIDTH/8 in copy mode; remaining count -= 1.
  - Remaining count reaches 0 → DONE.
  - Otherwise copy returns to RD; fill stays in WR.
- DONE lasts one cycle, then → IDLE.
- Addresses wrap modulo 2^ADDR_WIDTH.
- Transfer order is ascending. Overlap with dst ≤ src copies correctly. Overlap with dst > src replicates source data; this is software's responsibility.
- start_i outside IDLE is ignored.
- abort_i in RD or WR → DONE next cycle with no further RAM access. A read already in flight is discarded. err_o=0.
- abort_i in IDLE or DONE has no effect.
- abort_i and the final WR in the same cycle: the write completes, then DONE.
- Reset, including mid-job: state IDLE; all outputs 0; pointers, count and latched data cleared.

## Timing
- Reset values: busy_o, done_o, err_o, ram_en_o, ram_we_o = 0; ram_addr_o, ram_wdata_o, ram_be_o = 0.
- Start accepted in cycle 0; the first RAM access is in cycle 1.
- Copy of N words: accesses in cycles 1..2N (RD/WR alternating); done_o in cycle 2N+1.
- Fill of N words: accesses in cycles 1..N; done_o in cycle N+1.
- Rejected job or len=0: done_o in cycle 1, no RAM access.
- busy_o = state ∈ {RD, WR}. done_o = state == DONE.
- A new start is accepted in the cycle after done_o.
- ram_* outputs decode combinationally from registered state and pointers. The only combinational input-to-output path is ram_rdata_i → ram_wdata_o.

## Structure
- Package ram_dma_pkg holds:
  - the state enum (IDLE/RD/WR/DONE);
  - the mode encodings (MODE_COPY=0, MODE_FILL=1);
  - a function returning the word-offset bit count log2(DATA_WIDTH/8).
- Single module, no sub-module. The address/count datapath is too small to split out.

## Test plan
- Fill: dst=0x10, len=4, fill=0xA5A5_0001 → writes to 0x10, 0x14, 0x18, 0x1C in cycles 1–4 with be=0xF; done_o in cycle 5; read-back all 0xA5A5_0001.
- Copy: preload 0x00..0x0C with 1,2,3,4; src=0x00, dst=0x40, len=4 → RD/WR alternate in cycles 1–8; done_o in cycle 9; 0x40..0x4C read back 1,2,3,4.
- Reject: src=0x02 in copy mode → done_o in cycle 1, err_o=1, ram_en_o never high. Then len=0 → done_o with err_o=0.
- Wrap: fill with dst=0xF8, len=4 → writes to 0xF8, 0xFC, 0x00, 0x04.
- Abort in the RD of word 2 of a len=8 copy → no write for word 2, done_o next cycle, only word 1 copied. A start during busy has no effect.
- Assert rstn_i low in mid-fill → all outputs 0 immediately. After release, a new len=1 fill completes normally.
